// File: rtl/fft_stream_pkg.sv
// Shared types and defaults for the FFT output stream path.
package fft_stream_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_N     = 16;
  localparam int LOG2N     = $clog2(DEF_N);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] re;
    logic [DEF_WIDTH-1:0] im;
  } sample_t;

endpackage

// File: rtl/frame_buf.sv
// N-entry complex-sample register file: one synchronous write port, one combinational read port.
module frame_buf #(
  parameter int WIDTH = 64,
  parameter int N     = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] waddr,
  input  logic [WIDTH-1:0]     wr_real,
  input  logic [WIDTH-1:0]     wr_im,
  input  logic [$clog2(N)-1:0] raddr,
  output logic [WIDTH-1:0]     rd_real,
  output logic [WIDTH-1:0]     rd_im
);

  logic [2*WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {wr_real, wr_im};
  end

  assign {rd_real, rd_im} = mem[raddr];

endmodule

// File: rtl/fft_frame_collector.sv
// Captures one N-sample complex frame from the FFT serializer and replays it over ready/valid.
// Optional DIV16_EN: round(x/N) normalization applied to each word as it is written.
module fft_frame_collector
  import fft_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sof,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_real,
  input  logic [WIDTH-1:0]     in_im,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_real,
  output logic [WIDTH-1:0]     m_im,
  output logic [$clog2(N)-1:0] m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_err
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  state_t state, next_state;
  logic [LOGN-1:0] wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt, wr_addr;
  logic wr_en, set_err;
  logic [WIDTH-1:0] rd_real, rd_im;

  // Rounded divide by N, computed one bit wider so the +N/2 bias cannot overflow.
  function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] x);
`ifdef DIV16_EN
    logic signed [WIDTH:0] t;
    t = $signed({x[WIDTH-1], x}) + $signed((WIDTH+1)'(N / 2));
    t = t >>> LOGN;
    return t[WIDTH-1:0];
`else
    return x;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      state  <= next_state;
      wr_cnt <= wr_cnt_nxt;
      rd_cnt <= rd_cnt_nxt;
    end
  end

  always_comb begin
    next_state = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    wr_addr    = wr_cnt;
    wr_en      = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (sof) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_cnt_nxt = LOGN'(1);
            next_state = FILL;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (sof) begin
            wr_addr    = '0;
            wr_cnt_nxt = LOGN'(1);
            set_err    = 1'b1;
          end else begin
            wr_cnt_nxt = wr_cnt + LOGN'(1);
            if (wr_cnt == LAST_IDX) begin
              next_state = DRAIN;
              rd_cnt_nxt = '0;
            end
          end
        end
      end
      DRAIN: begin
        if (in_valid) set_err = 1'b1;
        if (m_ready) begin
          rd_cnt_nxt = rd_cnt + LOGN'(1);
          if (rd_cnt == LAST_IDX) next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A new error in the same cycle as clr_err must not be lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (set_err) overrun <= 1'b1;
    else if (clr_err) overrun <= 1'b0;
  end

  frame_buf #(.WIDTH(WIDTH), .N(N)) u_buf (
    .clk     (clk),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wr_real (norm(in_real)),
    .wr_im   (norm(in_im)),
    .raddr   (rd_cnt),
    .rd_real (rd_real),
    .rd_im   (rd_im)
  );

  // Outputs decode straight from the state register so reset clears them without a clock.
  assign m_valid = (state == DRAIN);
  assign busy    = (state != IDLE);
  assign m_index = m_valid ? rd_cnt : '0;
  assign m_real  = m_valid ? rd_real : '0;
  assign m_im    = m_valid ? rd_im : '0;
  assign m_last  = m_valid && (rd_cnt == LAST_IDX);

endmodule

// File: tb/tb_fft_frame_collector.sv
// Randomized bench for fft_frame_collector against a queue-based frame model.
module tb_fft_frame_collector;
  import fft_stream_pkg::*;

  localparam int W  = 64;
  localparam int NN = 16;

  logic clk = 0, rst = 0, sof = 0, in_valid = 0, m_ready = 0, clr_err = 0;
  logic [W-1:0] in_real = '0, in_im = '0;
  logic m_valid, m_last, busy, overrun;
  logic [W-1:0] m_real, m_im;
  logic [3:0] m_index;

  fft_frame_collector #(.WIDTH(W), .N(NN)) dut (
    .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid),
    .in_real(in_real), .in_im(in_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_im(m_im),
    .m_index(m_index), .m_last(m_last), .busy(busy), .overrun(overrun),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] scl(input logic [63:0] x);
`ifdef DIV16_EN
    logic signed [64:0] t;
    t = $signed({x[63], x}) + 65'sd8;
    t = t >>> 4;
    return t[63:0];
`else
    return x;
`endif
  endfunction

  // Frame model: words collected since the last accepted sof, and a drain queue.
  sample_t fill_q[$];
  sample_t drain_q[$];
  bit filling = 0;
  bit err = 0;
  int out_idx = 0;
  logic [63:0] hs_re[$];
  logic [63:0] hs_im[$];

  always @(negedge clk) begin
    bit set, exp_v;
    sample_t w;
    if (rst) begin
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_m_real", m_real, 64'd0);
      chk("rst_m_index", 64'(m_index), 64'd0);
      fill_q.delete();
      drain_q.delete();
      filling = 0;
      err = 0;
      out_idx = 0;
    end else begin
      exp_v = (drain_q.size() != 0);
      chk("m_valid", 64'(m_valid), 64'(exp_v));
      chk("busy", 64'(busy), 64'(filling || exp_v));
      chk("overrun", 64'(overrun), 64'(err));
      if (exp_v) begin
        chk("m_index", 64'(m_index), 64'(out_idx));
        chk("m_last", 64'(m_last), 64'(out_idx == NN - 1));
        chk("m_real", m_real, drain_q[0].re);
        chk("m_im", m_im, drain_q[0].im);
      end else begin
        chk("idle_m_index", 64'(m_index), 64'd0);
        chk("idle_m_real", m_real, 64'd0);
        chk("idle_m_last", 64'(m_last), 64'd0);
      end
      if (m_valid && m_ready) begin
        hs_re.push_back(m_real);
        hs_im.push_back(m_im);
      end
      set = 0;
      w.re = scl(in_real);
      w.im = scl(in_im);
      if (exp_v) begin
        if (in_valid) set = 1;
        if (m_ready) begin
          void'(drain_q.pop_front());
          out_idx++;
        end
      end else if (filling) begin
        if (in_valid) begin
          if (sof) begin
            fill_q.delete();
            set = 1;
          end
          fill_q.push_back(w);
          if (fill_q.size() == NN) begin
            drain_q = fill_q;
            fill_q.delete();
            filling = 0;
            out_idx = 0;
          end
        end
      end else if (in_valid) begin
        if (sof) begin
          fill_q.delete();
          fill_q.push_back(w);
          filling = 1;
        end else set = 1;
      end
      if (set) err = 1;
      else if (clr_err) err = 0;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [63:0] re,
                       input logic [63:0] im, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    in_valid = v; sof = s; in_real = re; in_im = im; m_ready = rdy; clr_err = clr;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < NN; k++)
      drive(1'b1, k == 0, 64'(base + k), -64'(base + k), 1'b1, 1'b0);
  endtask

  // mode 0: m_ready held high; mode 1: m_ready pattern 1,0,0,1
  task automatic wait_idle(input int mode);
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      drive(1'b0, 1'b0, '0, '0, (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3)), 1'b0);
      if (!busy) done = 1;
    end
    chk("wait_idle_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit got;
    #1 rst = 1;
    #1;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_real", m_real, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // basic frame, ready high
    base = hs_re.size();
    send_frame(0);
    chk("pre_rise_m_valid", 64'(m_valid), 64'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("rise_m_valid", 64'(m_valid), 64'd1);
    chk("rise_m_index", 64'(m_index), 64'd0);
    wait_idle(0);
    chk("basic_count", 64'(hs_re.size() - base), 64'd16);
    chk("basic_re15", hs_re[base + 15], scl(64'd15));
    chk("basic_im15", hs_im[base + 15], scl(-64'd15));
    chk("basic_overrun", 64'(overrun), 64'd0);

    // backpressure
    base = hs_re.size();
    send_frame(40);
    wait_idle(1);
    chk("bp_count", 64'(hs_re.size() - base), 64'd16);
    chk("bp_re7", hs_re[base + 7], scl(64'd47));

    // overrun: idle drop, clear, set-vs-clear, drops during drain
    drive(1'b1, 1'b0, 64'd55, 64'd55, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("idle_drop_overrun", 64'(overrun), 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("clr_overrun", 64'(overrun), 64'd0);
    drive(1'b1, 1'b0, 64'd56, 64'd56, 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("set_wins_overrun", 64'(overrun), 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    base = hs_re.size();
    send_frame(60);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'hdead, 64'hbeef, i[0], 1'b0);
    wait_idle(0);
    chk("drain_drop_overrun", 64'(overrun), 64'd1);
    chk("drain_drop_count", 64'(hs_re.size() - base), 64'd16);
    chk("drain_drop_re15", hs_re[base + 15], scl(64'd75));
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);

    // restart after 7 words
    for (int k = 0; k < 7; k++) drive(1'b1, k == 0, 64'(k), 64'(k), 1'b1, 1'b0);
    base = hs_re.size();
    send_frame(100);
    wait_idle(0);
    chk("restart_re0", hs_re[base], scl(64'd100));
    chk("restart_re15", hs_re[base + 15], scl(64'd115));
    chk("restart_overrun", 64'(overrun), 64'd1);

    // reset after 5 drain handshakes
    base = hs_re.size();
    send_frame(200);
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      if (hs_re.size() - base >= 5) got = 1;
    end
    chk("five_hs_reached", 64'(got), 64'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_m_valid", 64'(m_valid), 64'd0);
    chk("async_rst_m_real", m_real, 64'd0);
    chk("async_rst_m_index", 64'(m_index), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    base = hs_re.size();
    send_frame(300);
    wait_idle(0);
    chk("post_rst_count", 64'(hs_re.size() - base), 64'd16);
    chk("post_rst_re0", hs_re[base], scl(64'd300));

`ifdef DIV16_EN
    begin
      logic [63:0] dv [4];
      dv[0] = 64'd23; dv[1] = 64'd24; dv[2] = -64'd24; dv[3] = 64'd1 << 62;
      base = hs_re.size();
      for (int k = 0; k < NN; k++)
        drive(1'b1, k == 0, (k < 4) ? dv[k] : 64'd0, (k < 4) ? dv[k] : 64'd0, 1'b1, 1'b0);
      wait_idle(0);
      chk("div_23", hs_re[base], 64'd1);
      chk("div_24", hs_re[base + 1], 64'd2);
      chk("div_m24", hs_re[base + 2], -64'd1);
      chk("div_2p62", hs_im[base + 3], 64'd1 << 58);
    end
`endif

    // randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 3000; c++) begin
      logic v;
      v = ($urandom % 4) != 0;
      drive(v, v && (($urandom % 24) == 0), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom % 3) != 0, ($urandom % 50) == 0);
    end
    repeat (40) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
